// File: rtl/uart_packet_to_tilelink_if.sv
// Byte-stream and TileLink-frame signals of the UART packet to TileLink bridge.
// slave is the bridge's view, master the view of the side feeding bytes and taking frames.
interface uart_packet_to_tilelink_if;
   logic        byte_valid;
   logic        byte_ready;
   logic [7:0]  byte_data;
   logic        tl_in_valid;
   logic        tl_in_ready;
   logic [2:0]  tl_in_bits_chanId;
   logic [2:0]  tl_in_bits_opcode;
   logic [2:0]  tl_in_bits_param;
   logic        tl_in_bits_corrupt;
   logic [7:0]  tl_in_bits_size;
   logic [8:0]  tl_in_bits_union;
   logic [7:0]  tl_in_bits_source;
   logic [63:0] tl_in_bits_address;
   logic [63:0] tl_in_bits_data;
   logic [7:0]  packets_dropped;

   modport slave (
      input  byte_valid, byte_data, tl_in_ready,
      output byte_ready, tl_in_valid, tl_in_bits_chanId, tl_in_bits_opcode,
             tl_in_bits_param, tl_in_bits_corrupt, tl_in_bits_size, tl_in_bits_union,
             tl_in_bits_source, tl_in_bits_address, tl_in_bits_data, packets_dropped
   );

   modport master (
      output byte_valid, byte_data, tl_in_ready,
      input  byte_ready, tl_in_valid, tl_in_bits_chanId, tl_in_bits_opcode,
             tl_in_bits_param, tl_in_bits_corrupt, tl_in_bits_size, tl_in_bits_union,
             tl_in_bits_source, tl_in_bits_address, tl_in_bits_data, packets_dropped
   );
endinterface

// File: rtl/uart_packet_to_tilelink.sv
// Assembles 16-byte little-endian "<BBBBLQ" host packets into one TileLink frame each.
// Optional inter-byte idle timeout that discards partial packets: UART_TL_TIMEOUT_EN.
module uart_packet_to_tilelink #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0]  SOURCE_ID      = 8'h00
) (
   input logic                     clk,
   input logic                     reset_n,
   uart_packet_to_tilelink_if.slave bus
);

   localparam int unsigned PKT_BYTES = 16;
   localparam int unsigned IDX_W     = 4;
   localparam int unsigned BUF_W     = PKT_BYTES * 8;

   typedef enum logic {COLLECT, EMIT} state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [BUF_W-1:0]   buffer;
   logic               byte_ready_q;
   logic               tl_valid_q;
   logic               accept_c;
   logic               timeout_hit_c;

   if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   assign accept_c = (state == COLLECT) && bus.byte_valid && byte_ready_q;

   // Packet collection and frame hand-off
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= COLLECT;
         idx          <= '0;
         buffer       <= '0;
         byte_ready_q <= 1'b1;
         tl_valid_q   <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (accept_c) begin
                  buffer[{idx, 3'b000} +: 8] <= bus.byte_data;
                  idx <= idx + IDX_W'(1);
                  if (idx == IDX_W'(PKT_BYTES - 1)) begin
                     state        <= EMIT;
                     byte_ready_q <= 1'b0;
                     tl_valid_q   <= 1'b1;
                  end
               end else if (timeout_hit_c) begin
                  idx    <= '0;
                  buffer <= '0;
               end
            end
            EMIT: begin
               if (bus.tl_in_ready) begin
                  state        <= COLLECT;
                  byte_ready_q <= 1'b1;
                  tl_valid_q   <= 1'b0;
               end
            end
            default: begin
               state        <= COLLECT;
               byte_ready_q <= 1'b1;
               tl_valid_q   <= 1'b0;
            end
         endcase
      end
   end

`ifdef UART_TL_TIMEOUT_EN
   localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

   logic [31:0] idle_cnt;
   logic [7:0]  dropped;

   // A byte arriving on the limit cycle wins over the timeout
   assign timeout_hit_c = (state == COLLECT) && !accept_c && (idx != '0) &&
                          ((idle_cnt + 32'd1) == TIMEOUT_LIMIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt <= '0;
      end else if (accept_c || timeout_hit_c) begin
         idle_cnt <= '0;
      end else if ((state == COLLECT) && (idx != '0)) begin
         idle_cnt <= idle_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dropped <= '0;
      end else if (timeout_hit_c && (dropped != 8'hFF)) begin
         dropped <= dropped + 8'd1;
      end
   end

   assign bus.packets_dropped = dropped;
`else
   assign timeout_hit_c       = 1'b0;
   assign bus.packets_dropped = 8'h00;
`endif

   // Frame fields decoded straight from the registered packet buffer
   assign bus.byte_ready         = byte_ready_q;
   assign bus.tl_in_valid        = tl_valid_q;
   assign bus.tl_in_bits_chanId  = buffer[2:0];
   assign bus.tl_in_bits_opcode  = buffer[10:8];
   assign bus.tl_in_bits_param   = buffer[14:12];
   assign bus.tl_in_bits_corrupt = buffer[15];
   assign bus.tl_in_bits_size    = buffer[23:16];
   assign bus.tl_in_bits_union   = {1'b0, buffer[31:24]};
   assign bus.tl_in_bits_source  = SOURCE_ID;
   assign bus.tl_in_bits_address = {32'h0, buffer[63:32]};
   assign bus.tl_in_bits_data    = buffer[127:64];

   // byte0[7:3] and byte1[3] carry no frame information
   logic unused_bits;
   assign unused_bits = ^{buffer[7:3], buffer[11]};

endmodule

// File: tb/tb_uart_packet_to_tilelink.sv
// Directed bench for uart_packet_to_tilelink: inputs driven on falling edges,
// outputs sampled on falling edges; expected frame fields are hand-decoded constants.
module tb_uart_packet_to_tilelink;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   passed = 0;
   int   early_valid = 0;

   always #5 clk = ~clk;

   uart_packet_to_tilelink_if bus ();

   uart_packet_to_tilelink #(
      .TIMEOUT_CYCLES (20),
      .SOURCE_ID      (8'h5A)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   logic [7:0] p1 [16] = '{8'h03, 8'h21, 8'h03, 8'hFF, 8'h78, 8'h56, 8'h34, 8'h12,
                           8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
   logic [7:0] p2 [16] = '{8'h05, 8'h80, 8'h10, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                           8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
   logic [7:0] p3 [16] = '{8'h07, 8'h08, 8'h06, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h80,
                           8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
   logic [7:0] p4 [16] = '{8'hFE, 8'h7A, 8'h02, 8'h01, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
                           8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
   logic [7:0] junk [16] = '{default: 8'hFF};
   logic [7:0] stream [32];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Offer bytes lo..hi, one accepted per handshake; returns on the falling edge after the last accept
   task automatic send_bytes(input logic [7:0] pkt [16], input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         int guard = 0;
         bus.byte_valid = 1'b1;
         bus.byte_data  = pkt[i];
         while (!bus.byte_ready && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 50) check("byte_ready_timeout", 64'(bus.byte_ready), 64'd1);
         if (bus.tl_in_valid) early_valid++;
         @(negedge clk);
      end
      bus.byte_valid = 1'b0;
   endtask

   task automatic check_frame(input string tag, input logic [2:0] chan, input logic [2:0] opc,
                              input logic [2:0] prm, input logic corr, input logic [7:0] sz,
                              input logic [8:0] uni, input logic [63:0] addr, input logic [63:0] dat);
      check({tag, ".valid"},   64'(bus.tl_in_valid),        64'd1);
      check({tag, ".early"},   64'(early_valid),            64'd0);
      check({tag, ".chanId"},  64'(bus.tl_in_bits_chanId),  64'(chan));
      check({tag, ".opcode"},  64'(bus.tl_in_bits_opcode),  64'(opc));
      check({tag, ".param"},   64'(bus.tl_in_bits_param),   64'(prm));
      check({tag, ".corrupt"}, 64'(bus.tl_in_bits_corrupt), 64'(corr));
      check({tag, ".size"},    64'(bus.tl_in_bits_size),    64'(sz));
      check({tag, ".union"},   64'(bus.tl_in_bits_union),   64'(uni));
      check({tag, ".source"},  64'(bus.tl_in_bits_source),  64'h5A);
      check({tag, ".address"}, bus.tl_in_bits_address,      addr);
      check({tag, ".data"},    bus.tl_in_bits_data,         dat);
      early_valid = 0;
   endtask

   initial begin
      int ptr;
      int cyc;
      int nframes;
      int fcyc [2];
      logic [63:0] fdata [2];
      logic [63:0] faddr [2];
      logic acc;

      bus.byte_valid  = 1'b0;
      bus.byte_data   = 8'h00;
      bus.tl_in_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst.valid",   64'(bus.tl_in_valid),        64'd0);
      check("rst.ready",   64'(bus.byte_ready),         64'd1);
      check("rst.source",  64'(bus.tl_in_bits_source),  64'h5A);
      check("rst.address", bus.tl_in_bits_address,      64'd0);
      check("rst.data",    bus.tl_in_bits_data,         64'd0);
      check("rst.union",   64'(bus.tl_in_bits_union),   64'd0);
      check("rst.dropped", 64'(bus.packets_dropped),    64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Basic packet, serializer always ready; valid lasts one cycle
      bus.tl_in_ready = 1'b1;
      send_bytes(p1, 0, 15);
      check_frame("p1", 3'd3, 3'd1, 3'd2, 1'b0, 8'h03, 9'h0FF, 64'h12345678, 64'h0123456789ABCDEF);
      @(negedge clk);
      check("p1.valid_drop", 64'(bus.tl_in_valid), 64'd0);
      check("p1.ready_back", 64'(bus.byte_ready),  64'd1);

      // Backpressure: frame held 5 cycles, next byte held off
      bus.tl_in_ready = 1'b0;
      send_bytes(p1, 0, 15);
      check_frame("hold", 3'd3, 3'd1, 3'd2, 1'b0, 8'h03, 9'h0FF, 64'h12345678, 64'h0123456789ABCDEF);
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h05;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold.valid",   64'(bus.tl_in_valid),   64'd1);
         check("hold.bready",  64'(bus.byte_ready),    64'd0);
         check("hold.data",    bus.tl_in_bits_data,    64'h0123456789ABCDEF);
         check("hold.address", bus.tl_in_bits_address, 64'h12345678);
      end
      bus.tl_in_ready = 1'b1;
      @(negedge clk);
      check("release.valid",  64'(bus.tl_in_valid), 64'd0);
      check("release.bready", 64'(bus.byte_ready),  64'd1);
      // Pending 0x05 must become byte 0 of the next frame exactly once
      send_bytes(p2, 0, 15);
      check_frame("p2", 3'd5, 3'd0, 3'd0, 1'b1, 8'h10, 9'h000, 64'h11223344, 64'h1122334455667788);
      @(negedge clk);

      // Byte1 bit3 ignored
      send_bytes(p3, 0, 15);
      check_frame("p3", 3'd7, 3'd0, 3'd0, 1'b0, 8'h06, 9'h07F, 64'h80000001, 64'h8070605040302010);
      @(negedge clk);

      // Two packets streamed with byte_valid held high
      for (int i = 0; i < 16; i++) begin
         stream[i]      = p1[i];
         stream[16 + i] = p4[i];
      end
      ptr = 0; cyc = 0; nframes = 0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = stream[0];
      while (ptr < 32 && cyc < 200) begin
         acc = bus.byte_ready;
         @(negedge clk);
         cyc++;
         if (acc) ptr++;
         if (ptr < 32) bus.byte_data = stream[ptr];
         if (bus.tl_in_valid) begin
            if (nframes < 2) begin
               fcyc[nframes]  = cyc;
               fdata[nframes] = bus.tl_in_bits_data;
               faddr[nframes] = bus.tl_in_bits_address;
            end
            nframes++;
         end
      end
      bus.byte_valid = 1'b0;
      check("stream.frames", 64'(nframes), 64'd2);
      check("stream.first",  64'(fcyc[0]), 64'd16);
      check("stream.gap",    64'(fcyc[1] - fcyc[0]), 64'd17);
      check("stream.data0",  fdata[0], 64'h0123456789ABCDEF);
      check("stream.addr0",  faddr[0], 64'h12345678);
      check("stream.data1",  fdata[1], 64'h0807060504030201);
      check("stream.addr1",  faddr[1], 64'hAABBCCDD);
      check("stream.chan1",  64'(bus.tl_in_bits_chanId), 64'd6);
      check("stream.op1",    64'(bus.tl_in_bits_opcode),  64'd2);
      check("stream.param1", 64'(bus.tl_in_bits_param),   64'd7);
      @(negedge clk);
      check("stream.idle", 64'(bus.tl_in_valid), 64'd0);

      // Reset in the middle of a packet discards it
      send_bytes(junk, 0, 6);
      reset_n = 1'b0;
      @(negedge clk);
      check("midrst.valid",  64'(bus.tl_in_valid),  64'd0);
      check("midrst.bready", 64'(bus.byte_ready),   64'd1);
      check("midrst.data",   bus.tl_in_bits_data,   64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      early_valid = 0;
      send_bytes(p3, 0, 15);
      check_frame("midrst", 3'd7, 3'd0, 3'd0, 1'b0, 8'h06, 9'h07F, 64'h80000001, 64'h8070605040302010);
      @(negedge clk);

`ifdef UART_TL_TIMEOUT_EN
      // 20 idle cycles after 5 bytes: partial dropped
      send_bytes(junk, 0, 4);
      repeat (20) @(negedge clk);
      check("to.dropped1", 64'(bus.packets_dropped), 64'd1);
      send_bytes(p1, 0, 15);
      check_frame("to.p1", 3'd3, 3'd1, 3'd2, 1'b0, 8'h03, 9'h0FF, 64'h12345678, 64'h0123456789ABCDEF);
      @(negedge clk);
      // 19 idle cycles: packet survives and spans both bursts
      send_bytes(p4, 0, 4);
      repeat (19) @(negedge clk);
      send_bytes(p4, 5, 15);
      check_frame("to.p4", 3'd6, 3'd2, 3'd7, 1'b0, 8'h02, 9'h001, 64'hAABBCCDD, 64'h0807060504030201);
      check("to.dropped_hold", 64'(bus.packets_dropped), 64'd1);
      @(negedge clk);
`else
      // Without the timeout a partial packet waits indefinitely
      send_bytes(p4, 0, 4);
      repeat (30) @(negedge clk);
      send_bytes(p4, 5, 15);
      check_frame("wait.p4", 3'd6, 3'd2, 3'd7, 1'b0, 8'h02, 9'h001, 64'hAABBCCDD, 64'h0807060504030201);
      check("wait.dropped", 64'(bus.packets_dropped), 64'd0);
      @(negedge clk);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/uart_packet_to_tilelink.md
Name: uart_packet_to_tilelink

Overview:
Inbound counterpart of the TileLink-to-UART response path. Accepts the host command byte stream from the STL UART client, one byte per handshake. Assembles fixed 16-byte packets in the same little-endian layout the host packs with struct "<BBBBLQ". Unpacks each packet into one TileLink frame and presents it to the GenericSerializer on a valid/ready interface.

Parameters:
TIMEOUT_CYCLES, 1000000, inter-byte idle cycles before a partial packet is discarded (only with UART_TL_TIMEOUT_EN); must be ≥ 1
SOURCE_ID, 0, constant driven on tl_in_bits_source

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
byte_valid  input  1  UART client byte available
byte_ready  output  1  bridge accepts byte this cycle
byte_data  input  8  received byte, packet byte 0 first
tl_in_valid  output  1  frame valid to GenericSerializer
tl_in_ready  input  1  serializer accepts frame
tl_in_bits_chanId  output  3  byte0[2:0]
tl_in_bits_opcode  output  3  byte1[2:0]
tl_in_bits_param  output  3  byte1[6:4]
tl_in_bits_corrupt  output  1  byte1[7]
tl_in_bits_size  output  8  byte2
tl_in_bits_union  output  9  {1'b0, byte3}
tl_in_bits_source  output  8  SOURCE_ID
tl_in_bits_address  output  64  {32'h0, bytes7..4}, byte4 = LSB
tl_in_bits_data  output  64  bytes15..8, byte8 = LSB
packets_dropped  output  8  saturating count of timed-out partial packets (0 when feature off)

Behaviour:
- Reset (async assert, release synchronous to clk):
  - state=COLLECT, byte index=0, packet buffer=0, tl_in_valid=0, byte_ready=1.
  - All tl_in_bits = 0 except source = SOURCE_ID.
  - packets_dropped=0.
- States: COLLECT, EMIT.
- COLLECT:
  - byte_ready=1.
  - On byte_valid&&byte_ready, store byte_data into buffer[8*idx +: 8] and increment idx (4-bit).
  - On acceptance of the byte with idx==15: idx wraps to 0, state→EMIT, tl_in_valid=1 from the next cycle.
  - Latency: last byte accepted at cycle N → tl_in_valid high at N+1.
- EMIT:
  - byte_ready=0; incoming bytes are held off, never dropped.
  - tl_in_valid=1; all tl_in_bits are stable, driven from the registered buffer.
  - On tl_in_ready: tl_in_valid←0, state→COLLECT, byte_ready=1 the next cycle.
  - tl_in_ready may already be high on the first EMIT cycle → single-cycle EMIT.
- Throughput: one frame per 17 cycles minimum (16 byte cycles + 1 EMIT cycle). No bypass.
- Byte1 bit3 (unused) is ignored.
- No field validation; any chanId/opcode value is passed through unchanged.
- reset_n asserted mid-packet or mid-EMIT: partial packet and pending frame are discarded, no frame emitted.
- tl_in_ready while tl_in_valid=0: ignored.

Optional Feature:
- Macro: UART_TL_TIMEOUT_EN.
- When defined:
  - 32-bit idle counter clears on each accepted byte.
  - Counter increments each COLLECT cycle while idx≠0 and no byte is accepted.
  - On reaching TIMEOUT_CYCLES: idx←0, counter←0, packets_dropped increments (saturates at 255). Partial buffer contents are discarded.
  - Byte accepted on the same cycle the counter would reach the limit: the byte wins, no timeout.
  - Counter is inactive in EMIT and when idx==0.
- When undefined:
  - No counter logic; a partial packet waits indefinitely.
  - packets_dropped tied to 0.

Test Plan:
- Reset then bytes 03,21,03,FF,78,56,34,12,EF,CD,AB,89,67,45,23,01 back-to-back, tl_in_ready=1 -> one frame:
  - chanId=3, opcode=1, param=2, corrupt=0, size=3, union=0x0FF
  - address=0x12345678, data=0x0123456789ABCDEF, source=SOURCE_ID
  - tl_in_valid high exactly one cycle after the 16th byte.
- Same packet with tl_in_ready=0 for 5 cycles -> tl_in_valid and bits held stable, byte_ready=0 throughout, 17th offered byte not consumed until cycle after tl_in_ready.
- Byte1=0x80 -> corrupt=1, opcode=0, param=0; byte1=0x08 -> all three zero.
- Two packets streamed with byte_valid always high -> two frames in order, 17-cycle spacing, no lost/duplicated byte.
- reset_n pulsed low after 7 bytes, then a full 16-byte packet -> exactly one frame, matching the post-reset packet.
- UART_TL_TIMEOUT_EN, TIMEOUT_CYCLES=20: 5 bytes, 20 idle cycles, then full packet -> packets_dropped=1, one correct frame; repeat with 19 idle cycles -> no drop, frame spans both byte bursts.
